add8u_err_monitor: RTL and testbench
====================================

# add8u_err_monitor

Streaming error-statistics collector that sits directly downstream of an 8-bit approximate adder (add8u family). Each accepted sample is an operand pair A/B plus the 9-bit sum the approximate adder returned for those operands. The block recomputes the exact sum and accumulates mean-absolute, worst-case and error-probability statistics over a programmed number of samples. It is the in-fabric counterpart of the offline MAE/WCE/EP characterisation and feeds a readout/CSR block.

## Interface
Parameters:
- N_W, 16, width of the sample counter and of `cfg_n`/`err_cnt`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `cfg_n`  in  N_W  samples per run; captured on accepted `start`.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  block accepts a sample this cycle.
- `a`, `b`  in  8 each  operands.
- `approx_o`  in  9  approximate adder output for `a`,`b`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse; results final.
- `err_sum`  out  N_W+9  sum of |exact − approx|.
- `wce`  out  9  maximum |exact − approx| seen.
- `err_cnt`  out  N_W  samples with nonzero error.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start` → RUN: latch `cfg_n`; clear `err_sum`, `wce`, `err_cnt`, accept counter. If `cfg_n`==0 → DRAIN directly.
- RUN: `in_ready`=1 while accepted < `cfg_n`. Transfer on `in_valid && in_ready`. The last accept moves to DRAIN.
- Pipeline stage S1 registers `a`, `b`, `approx_o`, valid.
- Stage S2 computes exact = a+b (9 bits) and diff = |exact − approx_o| (9 bits, unsigned). It then updates accumulators: `err_sum` += diff; `wce` = max(wce, diff); `err_cnt` += (diff≠0).
- DRAIN: `in_ready`=0. Wait until S1 is empty, then → DONE.
- DONE: `done` high exactly one cycle on entry; results held stable until the next accepted `start`. `busy` is low in IDLE and DONE.
- `start` while `busy`: ignored. `in_valid` outside RUN: ignored; no state change.
- Width rules: `err_sum` cannot overflow (2^N_W − 1 samples × 510 max). Counters do not wrap within a run.
- `approx_o` values above 510 are legal; the difference is still taken as absolute value.

## Timing
- Reset: state IDLE; `in_ready`=0, `busy`=0, `done`=0, `err_sum`=0, `wce`=0, `err_cnt`=0; pipeline valids cleared.
- `rst` mid-run aborts the run: everything returns to reset values next cycle and no `done` pulse is emitted.
- `start` accepted in cycle t → `busy`=1 and `in_ready`=1 in cycle t+1 (for `cfg_n`>0).
- Sample accepted in cycle t → accumulators reflect it in cycle t+2.
- Last sample accepted in cycle t → `in_ready`=0 in t+1; `done`=1 and `busy`=0 in cycle t+2, with final values.
- `cfg_n`=0: `start` in cycle t → `done` in cycle t+2, all stats 0.
- Back-to-back samples sustain one per cycle. Bubbles on `in_valid` stall only the counter.
- `start` in the same cycle as the `done` pulse is accepted; that cycle's results remain visible during it.

## Test plan
- Exact samples: `cfg_n`=3, pairs (1,2,3), (255,255,510), (0,0,0) streamed back-to-back → `done` 2 cycles after last accept; `err_sum`=0, `wce`=0, `err_cnt`=0.
- Mixed errors: `cfg_n`=4, approx errors +3, −11, 0, −2 (e.g. a=15, b=1, approx=13 gives diff 3) → `err_sum`=16, `wce`=11, `err_cnt`=3.
- Backpressure/bubbles: `cfg_n`=5, `in_valid` toggled 1,0,0,1,… → exactly 5 transfers. `in_ready` drops the cycle after the 5th; extra valid samples are not counted.
- Zero-length and restart: `cfg_n`=0 → `done` at t+2 with zeros. A `start` during the `done` cycle launches a new run with cleared stats.
- Reset mid-run: `rst` after 2 of 4 samples → next cycle all outputs are 0, state IDLE, and no `done` pulse is ever emitted for that run.
- Worst case: `cfg_n`=65535, each a=b=255, approx=0 → `err_sum`=65535×510, `wce`=510, `err_cnt`=65535, no overflow.

Source files
------------

// File: rtl/add8u_err_monitor_if.sv
// Sample/control bundle between an add8u approximate-adder stream and the
// error-statistics monitor.
//
// Handshake: a sample (a, b, approx_o) transfers on a rising clk edge where
// in_valid && in_ready are both high. in_ready never depends on in_valid, and
// a producer may raise or drop in_valid freely; a sample offered while
// in_ready is low is simply not taken.
interface add8u_err_monitor_if #(
  parameter int N_W = 16
);
  // Run control
  logic           start;
  logic [N_W-1:0] cfg_n;

  // Sample stream
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     a;
  logic [7:0]     b;
  logic [8:0]     approx_o;

  // Status and results
  logic           busy;
  logic           done;
  logic [N_W+8:0] err_sum;
  logic [8:0]     wce;
  logic [N_W-1:0] err_cnt;

  // Producer / readout side
  modport master (
    output start, cfg_n, in_valid, a, b, approx_o,
    input  in_ready, busy, done, err_sum, wce, err_cnt
  );

  // Monitor side
  modport slave (
    input  start, cfg_n, in_valid, a, b, approx_o,
    output in_ready, busy, done, err_sum, wce, err_cnt
  );
endinterface

// File: rtl/add8u_err_monitor.sv
// Streaming error-statistics collector for an 8-bit approximate adder.
// Every accepted sample carries operands a/b and the sum the approximate
// adder produced; the block recomputes the exact sum and accumulates the
// sum of absolute errors, the worst-case error and the count of erroneous
// samples over a run of cfg_n samples.
//
// Pipeline: S1 registers the accepted sample; S2 forms |a+b - approx| from
// the S1 registers and folds it into the accumulators on the next edge, so a
// sample accepted in cycle t is visible in the results in cycle t+2.
module add8u_err_monitor #(
  parameter int N_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  add8u_err_monitor_if.slave     bus,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Control state
  state_t         state_q;
  logic [N_W-1:0] cfg_n_q;
  logic [N_W-1:0] acc_cnt_q;
  logic           in_ready_q;
  logic           busy_q;
  logic           done_q;

  // S1 sample registers
  logic           s1_valid_q;
  logic [7:0]     s1_a_q;
  logic [7:0]     s1_b_q;
  logic [8:0]     s1_x_q;

  // Accumulators
  logic [N_W+8:0] err_sum_q;
  logic [8:0]     wce_q;
  logic [N_W-1:0] err_cnt_q;

  // S2 combinational error
  logic [8:0]     s2_exact;
  logic [8:0]     s2_diff;

  logic           xfer;
  logic           start_ok;

  // A transfer can only happen while in_ready_q is high, i.e. in RUN.
  assign xfer     = bus.in_valid & in_ready_q;
  assign start_ok = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Run-control FSM; in_ready, busy and done are registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cfg_n_q    <= '0;
      acc_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            cfg_n_q   <= bus.cfg_n;
            acc_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (bus.cfg_n == '0) begin
              // Empty run: nothing to accept, go straight to the drain step.
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= ST_RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
            // cfg_n_q is nonzero in RUN, so cfg_n_q - 1 cannot underflow.
            if (acc_cnt_q == cfg_n_q - 1'b1) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Nothing is loaded into S1 during DRAIN, so whatever S1 holds now
          // reaches the accumulators on this same edge and S1 is empty
          // afterwards. DONE is therefore entered with final results.
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // S2 error: exact 9-bit sum against the adder's answer, absolute value.
  // approx values above 510 are legal and simply produce a larger error.
  always_comb begin
    s2_exact = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    s2_diff  = '0;
    if (s2_exact >= s1_x_q) begin
      s2_diff = s2_exact - s1_x_q;
    end else begin
      s2_diff = s1_x_q - s2_exact;
    end
  end

  // S1 capture of accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_x_q     <= '0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_a_q <= bus.a;
        s1_b_q <= bus.b;
        s1_x_q <= bus.approx_o;
      end
    end
  end

  // Accumulator update; an accepted start wipes the previous run's results.
  // err_sum is N_W+9 bits wide, enough for (2^N_W - 1) samples of error 510,
  // and err_cnt counts at most cfg_n samples, so neither can wrap in a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sum_q <= '0;
      wce_q     <= '0;
      err_cnt_q <= '0;
    end else if (start_ok) begin
      err_sum_q <= '0;
      wce_q     <= '0;
      err_cnt_q <= '0;
    end else if (s1_valid_q) begin
      err_sum_q <= err_sum_q + {{N_W{1'b0}}, s2_diff};
      if (s2_diff > wce_q) begin
        wce_q <= s2_diff;
      end
      if (s2_diff != '0) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_sum  = err_sum_q;
  assign bus.wce      = wce_q;
  assign bus.err_cnt  = err_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Directed-plus-random bench for add8u_err_monitor. A reference model keeps
// the absolute error of every sample the bench handed over and folds them
// into sum / max / nonzero-count with plain integer arithmetic.
module tb_add8u_err_monitor;
  localparam int N_W = 16;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_o;
  always #5 clk = ~clk;

  add8u_err_monitor_if #(.N_W(N_W)) bus ();

  add8u_err_monitor #(.N_W(N_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // Scoreboard
  logic [8:0] exp_q[$];
  int dir_a[$];
  int dir_b[$];
  int dir_x[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dir(input int a, input int b, input int x);
    dir_a.push_back(a);
    dir_b.push_back(b);
    dir_x.push_back(x);
  endtask

  task automatic check_stats(input string tag);
    longint s = 0;
    int w = 0;
    int c = 0;
    foreach (exp_q[i]) begin
      s += exp_q[i];
      if (int'(exp_q[i]) > w) w = exp_q[i];
      if (exp_q[i] != 0) c++;
    end
    check({tag, "_err_sum"}, bus.err_sum, s);
    check({tag, "_wce"}, bus.wce, w);
    check({tag, "_err_cnt"}, bus.err_cnt, c);
  endtask

  // Driver: pulse start with cfg_n; lands in the cycle after the start.
  task automatic start_run(input string tag, input int n);
    bus.start = 1'b1;
    bus.cfg_n = n[N_W-1:0];
    tick();
    bus.start = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy, 1);
    check({tag, "_ready_after_start"}, bus.in_ready, (n > 0) ? 1 : 0);
    check({tag, "_cleared_sum"}, bus.err_sum, 0);
    check({tag, "_cleared_wce"}, bus.wce, 0);
    check({tag, "_cleared_cnt"}, bus.err_cnt, 0);
  endtask

  // Driver: offer samples until n are taken, then verify the done cycle.
  // vmode 0: valid every cycle, 1: valid pattern 1,0,0, 2: random valid.
  task automatic stream(input string tag, input int n, input int vmode,
                        input int worst, input int budget);
    int acc = 0;
    int cyc = 0;
    int d;
    logic v;
    logic [7:0] sa, sb;
    logic [8:0] sx;
    exp_q.delete();
    while (acc < n && cyc < budget) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (dir_a.size() > 0) begin
        sa = dir_a[0][7:0];
        sb = dir_b[0][7:0];
        sx = dir_x[0][8:0];
      end else if (worst != 0) begin
        sa = 8'd255;
        sb = 8'd255;
        sx = 9'd0;
      end else begin
        sa = 8'($urandom_range(0, 255));
        sb = 8'($urandom_range(0, 255));
        sx = 9'($urandom_range(0, 511));
      end
      bus.in_valid = v;
      bus.a        = sa;
      bus.b        = sb;
      bus.approx_o = sx;
      // A start while busy must be ignored.
      if (vmode == 1 && cyc == 1) begin
        bus.start = 1'b1;
        bus.cfg_n = 1;
      end else begin
        bus.start = 1'b0;
      end
      if (v && bus.in_ready === 1'b1) begin
        d = int'(sa) + int'(sb) - int'(sx);
        if (d < 0) d = -d;
        exp_q.push_back(d[8:0]);
        acc++;
        if (dir_a.size() > 0) begin
          void'(dir_a.pop_front());
          void'(dir_b.pop_front());
          void'(dir_x.pop_front());
        end
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_accepted"}, acc, n);
    // Cycle after the last accept: ready drops, still busy, no done yet.
    check({tag, "_ready_drop"}, bus.in_ready, 0);
    check({tag, "_busy_drain"}, bus.busy, 1);
    check({tag, "_no_early_done"}, bus.done, 0);
    // Offer a large-error sample that must not be counted.
    bus.in_valid = 1'b1;
    bus.a        = 8'd255;
    bus.b        = 8'd255;
    bus.approx_o = 9'd0;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_done"}, bus.busy, 0);
    check({tag, "_state_done"}, state_o, 3);
    check_stats(tag);
  endtask

  int seen_done;
  int seen_ready;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.cfg_n    = '0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.approx_o = '0;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err_sum", bus.err_sum, 0);
    check("rst_wce", bus.wce, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    check("rst_state", state_o, 0);
    rst = 1'b0;

    // Valid in IDLE is ignored.
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("idle_state", state_o, 0);
    check("idle_ready", bus.in_ready, 0);
    tick();
    check("idle_cnt", bus.err_cnt, 0);

    // Mixed errors: +3, -11, 0, -2 -> sum 16, wce 11, cnt 3.
    push_dir(15, 1, 13);
    push_dir(100, 50, 161);
    push_dir(7, 8, 15);
    push_dir(200, 100, 302);
    start_run("mixed", 4);
    stream("mixed", 4, 0, 0, 20);
    check("mixed_const_sum", bus.err_sum, 16);
    check("mixed_const_wce", bus.wce, 11);

    // Start during the done cycle: exact samples, stats must clear.
    push_dir(1, 2, 3);
    push_dir(255, 255, 510);
    push_dir(0, 0, 0);
    start_run("exact", 3);
    stream("exact", 3, 0, 0, 20);

    // Zero-length run launched from the done cycle.
    start_run("zero", 0);
    check("zero_no_done_t1", bus.done, 0);
    tick();
    check("zero_done_t2", bus.done, 1);
    check("zero_busy_t2", bus.busy, 0);
    check_stats("zero");
    tick();
    check("zero_done_pulse", bus.done, 0);
    check("zero_hold_state", state_o, 3);

    // Bubbles on in_valid, start-while-busy ignored.
    start_run("bubble", 5);
    stream("bubble", 5, 1, 0, 40);
    tick();
    check("bubble_done_pulse", bus.done, 0);
    check_stats("bubble_hold");

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 24);
      int vm = $urandom_range(0, 2);
      start_run($sformatf("rand%0d", r), n);
      stream($sformatf("rand%0d", r), n, vm, 0, 400);
      if ((r % 2) == 0) tick();
    end

    // Reset mid-run after 2 of 4 samples.
    start_run("rstmid", 4);
    bus.in_valid = 1'b1;
    bus.a = 8'd10; bus.b = 8'd10; bus.approx_o = 9'd0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_state", state_o, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_ready", bus.in_ready, 0);
    check("rstmid_done", bus.done, 0);
    check("rstmid_err_sum", bus.err_sum, 0);
    check("rstmid_wce", bus.wce, 0);
    check("rstmid_err_cnt", bus.err_cnt, 0);
    seen_done = 0;
    seen_ready = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) seen_done++;
      if (bus.in_ready === 1'b1) seen_ready++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("rstmid_no_done", seen_done, 0);
    check("rstmid_no_ready", seen_ready, 0);
    check("rstmid_cnt_after", bus.err_cnt, 0);

    // Worst case: 65535 samples of error 510.
    start_run("worst", 65535);
    stream("worst", 65535, 0, 1, 70000);
    check("worst_const_sum", bus.err_sum, 64'd65535 * 64'd510);
    check("worst_const_wce", bus.wce, 510);
    check("worst_const_cnt", bus.err_cnt, 65535);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
